// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-code sequencer.
package gray_seq_pkg;

   localparam int unsigned DefaultW = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Binary to Gray on a 32-bit container; callers zero-extend narrower codes.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary on a 32-bit container; zero-extended input gives zero-extended output.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/b2g_conv.sv
// Purely combinational W-bit binary-to-Gray converter.
module b2g_conv
   import gray_seq_pkg::*;
#(
   parameter int unsigned W = DefaultW
) (
   input  logic [W-1:0] bin_i,
   output logic [W-1:0] gray_o
);

   assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// Autonomous Gray-code sequencer: walks a modular binary range and streams
// binary/Gray pairs over valid/ready. Optional self-check output chk_err is
// built only when GRAY_CHECK_EN is defined.
module gray_seq_ctrl
   import gray_seq_pkg::*;
#(
   parameter int unsigned W     = DefaultW,
   parameter int unsigned CNT_W = W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             dir,
   input  logic [W-1:0]     start_val,
   input  logic [W-1:0]     end_val,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [W-1:0]     bin_out,
   output logic [W-1:0]     gray_out,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic [CNT_W-1:0] emit_cnt
`ifdef GRAY_CHECK_EN
   ,
   output logic             chk_err
`endif
);

   state_e           state_q, state_d;
   logic [W-1:0]     bin_q, bin_d;
   logic [W-1:0]     gray_q, gray_d;
   logic [W-1:0]     end_q, end_d;
   logic             dir_q, dir_d;
   logic             wrap_q, wrap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             xfer;
   logic             load;

   // Gray is derived from the next binary code so both land in the same register stage.
   b2g_conv #(
      .W(W)
   ) u_b2g (
      .bin_i (bin_d),
      .gray_o(gray_d)
   );

   // abort suppresses both a start and a transfer in the same cycle
   assign xfer = (state_q == StRun) && out_ready && !abort;
   assign load = (state_q == StIdle) && start && !abort;

   // Next-state, code stepping, wrap detection and transfer counting.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      end_d   = end_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               dir_d   = dir;
               end_d   = end_val;
               bin_d   = start_val;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else if (xfer) begin
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (bin_q == end_q) begin
                  state_d = StDone;
               end else if (dir_q) begin
                  bin_d  = bin_q - 1'b1;
                  wrap_d = (bin_q == '0);
               end else begin
                  bin_d  = bin_q + 1'b1;
                  wrap_d = (bin_q == {W{1'b1}});
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         bin_q   <= '0;
         gray_q  <= '0;
         end_q   <= '0;
         dir_q   <= 1'b0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         gray_q  <= gray_d;
         end_q   <= end_d;
         dir_q   <= dir_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = (state_q == StRun);
   assign busy      = (state_q == StRun);
   assign done      = (state_q == StDone);
   assign wrap      = wrap_q;
   assign bin_out   = bin_q;
   assign gray_out  = gray_q;
   assign emit_cnt  = cnt_q;

`ifdef GRAY_CHECK_EN
   logic         chk_err_q, chk_err_d;
   logic         first_q, first_d;
   logic [W-1:0] prev_q, prev_d;
   logic [31:0]  g2b;

   // Per-transfer coherence and single-bit-step check; sticky until the next start.
   always_comb begin
      chk_err_d = chk_err_q;
      first_d   = first_q;
      prev_d    = prev_q;
      g2b       = gray2bin(32'(gray_q));
      if (load) begin
         chk_err_d = 1'b0;
         first_d   = 1'b1;
      end else if (xfer) begin
         if (g2b != 32'(bin_q)) begin
            chk_err_d = 1'b1;
         end
         if (!first_q && ($countones(gray_q ^ prev_q) != 1)) begin
            chk_err_d = 1'b1;
         end
         prev_d  = gray_q;
         first_d = 1'b0;
      end
   end

   // Checker registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_err_q <= 1'b0;
         first_q   <= 1'b1;
         prev_q    <= '0;
      end else begin
         chk_err_q <= chk_err_d;
         first_q   <= first_d;
         prev_q    <= prev_d;
      end
   end

   assign chk_err = chk_err_q;
`endif

endmodule
